alu_seq: RTL

- Parametrised, registered, multi-cycle successor to the single-cycle 8-bit datapath ALU.
- Adds width generalisation, carry/compare flags, and iterative barrel-free shifts by N bits and a shift-add multiplier. Both take multiple cycles, so the block has a START/BUSY/DONE handshake.
- Sits between the register file and the writeback mux. The control FSM raises START and stalls PC advance while BUSY is high.
- Branch offset generation is retained, with results registered.

---
 rtl/alu_seq.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered, multi-cycle ALU that sits between the register file
// and the writeback mux. Operands are captured on START; the result is
// presented with a one-cycle DONE pulse and held until the next DONE.
//
// Ports:
//   CLK      - clock, all state changes on the rising edge
//   RESET_N  - synchronous active-low reset (aborts any in-flight op)
//   START    - request, sampled only while BUSY=0
//   OP, T    - operation code and mode/carry-in bit, captured with START
//   INPUTA   - operand A (rs), captured with START
//   INPUTB   - operand B (r0), captured with START; B[SHW:0] is the shift count
//   BUSY     - operation in progress (EXEC or FIN)
//   DONE     - one-cycle pulse, result outputs updated this cycle
//   OUT      - result, held until the next DONE
//   ZERO     - OUT==0, registered with OUT
//   CARRY    - carry / borrow / last-bit-out / high-half-nonzero flag
//   bOFFSET  - branch offset magnitude (changes on BRC or reset only)
//   bSIGN    - branch direction, 1 = backward
module alu_seq #(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         START,
  input  logic [3:0]   OP,
  input  logic         T,
  input  logic [W-1:0] INPUTA,
  input  logic [W-1:0] INPUTB,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] OUT,
  output logic         ZERO,
  output logic         CARRY,
  output logic [W-1:0] bOFFSET,
  output logic         bSIGN
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_ASR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_EQ  = 4'd9;
  localparam logic [3:0] OP_LTU = 4'd10;
  localparam logic [3:0] OP_BRC = 4'd11;
  localparam logic [3:0] OP_ACC = 4'd12;

  localparam logic [SHW:0] CNT_FULL = (SHW+1)'(W);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
  localparam logic [W-1:0] OFS_ONE  = W'(1);

  // Shift counts of W or more all collapse to W iterations, which already
  // fully drains (or sign-fills) the operand.
  function automatic logic [SHW:0] sat_count(input logic [SHW:0] n);
    return (n >= CNT_FULL) ? CNT_FULL : n;
  endfunction

  // One shift iteration; returns {bit shifted out, shifted value}.
  function automatic logic [W:0] shift_step(input logic [3:0] op,
                                            input logic [W-1:0] v);
    case (op)
      OP_SHL:  return {v[W-1], v[W-2:0], 1'b0};
      OP_SHR:  return {v[0], 1'b0, v[W-1:1]};
      default: return {v[0], v[W-1], v[W-1:1]};
    endcase
  endfunction

  // Control / visible state (reset)
  logic [1:0]   state_q, state_d;
  logic         done_q, done_d;
  logic [W-1:0] out_q, out_d;
  logic         zero_q, zero_d;
  logic         carry_q, carry_d;
  logic [W-1:0] boff_q, boff_d;
  logic         bsign_q, bsign_d;

  // Captured operands and iteration datapath (not reset)
  logic [3:0]   op_q, op_d;
  logic         t_q, t_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] acc_q, acc_d;   // shift value, or multiplier / low product half
  logic [W-1:0] hi_q, hi_d;     // high product half
  logic [SHW:0] cnt_q, cnt_d;   // remaining EXEC iterations
  logic         shc_q, shc_d;   // last bit shifted out

  logic [W:0]   add_res;
  logic [W:0]   sub_res;
  logic [W:0]   mul_sum;
  logic [W:0]   shift_res;
  logic [SHW:0] n_sat;
  logic signed [W-1:0] a_s;
  logic signed [W-1:0] b_s;
  logic [W-1:0] res;
  logic         res_c;
  logic         lt;

  assign add_res   = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, t_q};
  // Bit W of the extended difference is the borrow.
  assign sub_res   = {1'b0, a_q} - {1'b0, b_q} - {{W{1'b0}}, t_q};
  // Shift-add step: conditionally add A into the high half, then the whole
  // {carry, hi, lo} word shifts right by one.
  assign mul_sum   = {1'b0, hi_q} + (acc_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  assign shift_res = shift_step(op_q, acc_q);
  assign n_sat     = sat_count(INPUTB[SHW:0]);
  assign a_s       = a_q;
  assign b_s       = b_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    out_d   = out_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    boff_d  = boff_q;
    bsign_d = bsign_q;
    op_d    = op_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    shc_d   = shc_q;
    res     = '0;
    res_c   = 1'b0;
    lt      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d  = OP;
          t_d   = T;
          a_d   = INPUTA;
          b_d   = INPUTB;
          hi_d  = '0;
          shc_d = 1'b0;
          acc_d = (OP == OP_MUL) ? INPUTB : INPUTA;
          if (OP == OP_MUL) begin
            cnt_d   = CNT_FULL;
            state_d = S_EXEC;
          end else if ((OP == OP_SHL || OP == OP_SHR || OP == OP_ASR) &&
                       (n_sat != '0)) begin
            cnt_d   = n_sat;
            state_d = S_EXEC;
          end else begin
            // Zero-count shifts fall through here with acc=A and carry 0.
            state_d = S_FIN;
          end
        end
      end

      S_EXEC: begin
        if (op_q == OP_MUL) begin
          hi_d  = mul_sum[W:1];
          acc_d = {mul_sum[0], acc_q[W-1:1]};
        end else begin
          shc_d = shift_res[W];
          acc_d = shift_res[W-1:0];
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        case (op_q)
          OP_ADD: begin
            res   = add_res[W-1:0];
            res_c = add_res[W];
          end
          OP_SUB: begin
            res   = sub_res[W-1:0];
            res_c = sub_res[W];
          end
          OP_XOR: res = a_q ^ b_q;
          OP_AND: res = a_q & b_q;
          OP_OR:  res = a_q | b_q;
          OP_SHL, OP_SHR, OP_ASR: begin
            res   = acc_q;
            res_c = shc_q;
          end
          OP_MUL: begin
            res   = t_q ? hi_q : acc_q;
            res_c = |hi_q;
          end
          OP_EQ:  res = {{(W-1){1'b0}}, (a_q == b_q) ^ t_q};
          OP_LTU: begin
            lt  = t_q ? (a_s < b_s) : (a_q < b_q);
            res = {{(W-1){1'b0}}, lt};
          end
          OP_ACC: res = a_q;
          default: res = '0;
        endcase

        // BRC touches only the branch outputs; OUT/ZERO/CARRY hold.
        if (op_q == OP_BRC) begin
          if (b_q == '0) begin
            boff_d  = a_q;
            bsign_d = t_q;
          end else begin
            boff_d  = OFS_ONE;
            bsign_d = 1'b0;
          end
        end else begin
          out_d   = res;
          zero_d  = (res == '0);
          carry_d = res_c;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      boff_q  <= OFS_ONE;
      bsign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      boff_q  <= boff_d;
      bsign_q <= bsign_d;
    end
  end

  always_ff @(posedge CLK) begin
    op_q  <= op_d;
    t_q   <= t_d;
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
    hi_q  <= hi_d;
    cnt_q <= cnt_d;
    shc_q <= shc_d;
  end

  assign BUSY    = (state_q != S_IDLE);
  assign DONE    = done_q;
  assign OUT     = out_q;
  assign ZERO    = zero_q;
  assign CARRY   = carry_q;
  assign bOFFSET = boff_q;
  assign bSIGN   = bsign_q;

endmodule
